// File: rtl/imm_gen_pkg.sv
// Immediate format codes and skid-buffer occupancy encoding shared by the immediate generator.
// Pure definitions: no latency, no flow control.
package imm_gen_pkg;

  localparam int IMM_TYPE_W = 3;

  typedef enum logic [IMM_TYPE_W-1:0] {
    NOIMM  = 3'd0,
    ITYPE  = 3'd1,
    STYPE  = 3'd2,
    BTYPE  = 3'd3,
    UTYPE  = 3'd4,
    JTYPE  = 3'd5,
    ZTYPE  = 3'd6,
    SHTYPE = 3'd7
  } imm_type_e;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } buf_cnt_e;

endpackage

// File: rtl/imm_expand.sv
// Combinational format mux: inst[31:7] -> XLEN-wide immediate plus illegal flag.
// Zero latency, no flow control.
module imm_expand
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]           inst_i,
  input  logic [IMM_TYPE_W-1:0] imm_type_i,
  output logic [XLEN-1:0]       imm_o,
  output logic                  illegal_o
);

  // Re-index so field slices read exactly like the ISA manual bit numbers.
  logic [31:7] w;
  assign w = inst_i;

  always_comb begin
    imm_o     = '0;
    illegal_o = 1'b0;
    case (imm_type_i)
      ITYPE:  imm_o = {{(XLEN-11){w[31]}}, w[30:20]};
      STYPE:  imm_o = {{(XLEN-11){w[31]}}, w[30:25], w[11:7]};
      BTYPE:  imm_o = {{(XLEN-12){w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      UTYPE:  imm_o = {{(XLEN-31){w[31]}}, w[30:12], 12'b0};
      JTYPE:  imm_o = {{(XLEN-20){w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      ZTYPE:  imm_o[4:0] = w[19:15];
      SHTYPE: begin
        if (XLEN == 64) begin
          imm_o[5:0] = w[25:20];
        end else begin
          imm_o[4:0] = w[24:20];
          illegal_o  = w[25];
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator feeding a 2-entry skid buffer; 1-cycle latency when empty.
// in_ready drops only when both entries are held, so ID/EX stalls never drop or duplicate.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [24:0]           in_inst,
  input  logic [IMM_TYPE_W-1:0] in_imm_type,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_imm,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_illegal
);

  logic [XLEN-1:0]  exp_imm;
  logic             exp_ill;

  buf_cnt_e         count_q, count_d;
  logic [XLEN-1:0]  head_imm_q, head_imm_d, tail_imm_q, tail_imm_d;
  logic [TAG_W-1:0] head_tag_q, head_tag_d, tail_tag_q, tail_tag_d;
  logic             head_ill_q, head_ill_d, tail_ill_q, tail_ill_d;
  logic             push, pop;

  imm_expand #(.XLEN(XLEN)) u_expand (
    .inst_i     (in_inst),
    .imm_type_i (in_imm_type),
    .imm_o      (exp_imm),
    .illegal_o  (exp_ill)
  );

  assign in_ready    = rst_n && (count_q != CNT_FULL);
  assign out_valid   = (count_q != CNT_EMPTY);
  assign out_imm     = head_imm_q;
  assign out_tag     = head_tag_q;
  assign out_illegal = head_ill_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    count_d    = count_q;
    head_imm_d = head_imm_q;
    head_tag_d = head_tag_q;
    head_ill_d = head_ill_q;
    tail_imm_d = tail_imm_q;
    tail_tag_d = tail_tag_q;
    tail_ill_d = tail_ill_q;
    if (flush) begin
      count_d = CNT_EMPTY;
    end else begin
      case (count_q)
        CNT_EMPTY: begin
          if (push) begin
            head_imm_d = exp_imm;
            head_tag_d = in_tag;
            head_ill_d = exp_ill;
            count_d    = CNT_ONE;
          end
        end
        CNT_ONE: begin
          if (push && pop) begin
            head_imm_d = exp_imm;
            head_tag_d = in_tag;
            head_ill_d = exp_ill;
          end else if (push) begin
            tail_imm_d = exp_imm;
            tail_tag_d = in_tag;
            tail_ill_d = exp_ill;
            count_d    = CNT_FULL;
          end else if (pop) begin
            count_d = CNT_EMPTY;
          end
        end
        default: begin
          // Full: push is blocked by in_ready, so only a pop can move the tail up.
          if (pop) begin
            head_imm_d = tail_imm_q;
            head_tag_d = tail_tag_q;
            head_ill_d = tail_ill_q;
            count_d    = CNT_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= CNT_EMPTY;
      head_imm_q <= '0;
      head_tag_q <= '0;
      head_ill_q <= 1'b0;
      tail_imm_q <= '0;
      tail_tag_q <= '0;
      tail_ill_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      head_imm_q <= head_imm_d;
      head_tag_q <= head_tag_d;
      head_ill_q <= head_ill_d;
      tail_imm_q <= tail_imm_d;
      tail_tag_q <= tail_tag_d;
      tail_ill_q <= tail_ill_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives XLEN=32 and XLEN=64 instances with shared stimulus and checks both against a queue model.
module tb_imm_gen_pipe;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [24:0] in_inst;
  logic [2:0]  in_imm_type;
  logic [31:0] in_tag;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_tag32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] imm32;
    logic        ill32;
    logic [63:0] imm64;
    logic        ill64;
    logic [31:0] tag;
  } exp_t;

  exp_t q[$];

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_imm_type(in_imm_type), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32), .out_illegal(out_illegal32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_imm_type(in_imm_type), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {illegal, imm} from the ISA field definitions using signed arithmetic.
  function automatic logic [64:0] ref_imm(logic [31:0] w, logic [2:0] t, int xlen);
    logic signed [63:0] s, a;
    logic [63:0] r;
    logic ill;
    s = $signed({{32{w[31]}}, w});
    r = '0;
    ill = 1'b0;
    case (t)
      3'd0: ill = 1'b1;
      3'd1: begin a = s >>> 20; r = a; end
      3'd2: begin a = s >>> 25; r = (a << 5) | 64'(w[11:7]); end
      3'd3: begin a = s >>> 31; r = (a << 12) | (64'(w[7]) << 11) | (64'(w[30:25]) << 5) | (64'(w[11:8]) << 1); end
      3'd4: begin r = s; r = r & ~64'hFFF; end
      3'd5: begin a = s >>> 31; r = (a << 20) | (64'(w[19:12]) << 12) | (64'(w[20]) << 11) | (64'(w[30:21]) << 1); end
      3'd6: r = 64'(w[19:15]);
      default: begin
        if (xlen == 64) r = 64'(w[25:20]);
        else begin r = 64'(w[24:20]); ill = w[25]; end
      end
    endcase
    if (xlen == 32) r = r & 64'h0000_0000_FFFF_FFFF;
    return {ill, r};
  endfunction

  task automatic drive_idle();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_imm_type = 3'd0; in_tag = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1; in_tag = $urandom; in_imm_type = 3'd1;
      n_checks++;
      if (out_valid32 !== 1'b0 || out_imm32 !== 32'h0 || out_tag32 !== 32'h0 || out_illegal32 !== 1'b0 ||
          in_ready32 !== 1'b0 || out_valid64 !== 1'b0 || out_imm64 !== 64'h0 || in_ready64 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset: v32=%b imm32=%h tag32=%h ill32=%b rdy32=%b v64=%b imm64=%h rdy64=%b, expected all 0",
                 out_valid32, out_imm32, out_tag32, out_illegal32, in_ready32, out_valid64, out_imm64, in_ready64);
      end
    end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1 || out_valid32 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy32=%b rdy64=%b v32=%b, expected rdy=1 v=0", in_ready32, in_ready64, out_valid32);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] vin [8] = '{32'hFFF00093, 32'hFE000EE3, 32'h008000EF, 32'h000FD073,
                             32'h80000037, 32'h03F01013, 32'h12345678, 32'h00000000};
    logic [2:0]  vty [8] = '{3'd1, 3'd3, 3'd5, 3'd6, 3'd4, 3'd7, 3'd0, 3'd1};
    logic [31:0] e32 [8] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h8, 32'h1F, 32'h80000000, 32'h1F, 32'h0, 32'h0};
    logic [63:0] e64 [8] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h8, 64'h1F,
                             64'hFFFFFFFF80000000, 64'h3F, 64'h0, 64'h0};
    logic        i32 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        i64 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] w;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      w = vin[i];
      in_valid = 1'b1; in_inst = w[31:7]; in_imm_type = vty[i]; in_tag = 32'(i + 100); out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (out_valid32 !== 1'b1 || out_imm32 !== e32[i] || out_illegal32 !== i32[i] || out_tag32 !== 32'(i + 100)) begin
        n_fail++;
        $display("FAIL vec%0d_x32: v=%b imm=%h ill=%b tag=%h, expected v=1 imm=%h ill=%b tag=%h",
                 i, out_valid32, out_imm32, out_illegal32, out_tag32, e32[i], i32[i], i + 100);
      end
      n_checks++;
      if (out_valid64 !== 1'b1 || out_imm64 !== e64[i] || out_illegal64 !== i64[i] || out_tag64 !== 32'(i + 100)) begin
        n_fail++;
        $display("FAIL vec%0d_x64: v=%b imm=%h ill=%b tag=%h, expected v=1 imm=%h ill=%b tag=%h",
                 i, out_valid64, out_imm64, out_illegal64, out_tag64, e64[i], i64[i], i + 100);
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    logic [64:0] r;
    w = $urandom;
    r = ref_imm(w, 3'd2, 32);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_inst = w[31:7]; in_imm_type = 3'd2; in_tag = 32'd1;
    @(negedge clk);
    in_inst = ~w[31:7]; in_tag = 32'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = (i == 0);
      in_tag = 32'd3;
      n_checks++;
      if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0 || out_valid32 !== 1'b1 ||
          out_tag32 !== 32'd1 || out_tag64 !== 32'd1 || out_imm32 !== r[31:0]) begin
        n_fail++;
        $display("FAIL stall%0d: rdy32=%b rdy64=%b v32=%b tag32=%h tag64=%h imm32=%h, expected rdy=0 v=1 tag=1 imm=%h",
                 i, in_ready32, in_ready64, out_valid32, out_tag32, out_tag64, out_imm32, r[31:0]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid32 !== 1'b1 || out_tag32 !== 32'd2 || out_tag64 !== 32'd2) begin
      n_fail++;
      $display("FAIL drain_second: v32=%b tag32=%h tag64=%h, expected v=1 tag=2", out_valid32, out_tag32, out_tag64);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: v32=%b v64=%b rdy32=%b, expected v=0 rdy=1", out_valid32, out_valid64, in_ready32);
    end
    drive_idle();
  endtask

  task automatic test_flush();
    // Flush while full, with a simultaneous input offered.
    @(negedge clk);
    in_valid = 1'b1; in_imm_type = 3'd1; in_inst = $urandom; in_tag = 32'h11;
    @(negedge clk);
    in_tag = 32'h12;
    @(negedge clk);
    flush = 1'b1; in_tag = 32'hBAD; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: v32=%b v64=%b rdy32=%b rdy64=%b, expected v=0 rdy=1",
               out_valid32, out_valid64, in_ready32, in_ready64);
    end
    // Flush with one entry: in_ready stays high, but the offered push is dropped.
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0; in_tag = 32'h21;
    @(negedge clk);
    flush = 1'b1; in_tag = 32'h22; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ready: rdy32=%b rdy64=%b, expected 1", in_ready32, in_ready64);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_drop%0d: v32=%b v64=%b tag32=%h, expected v=0", i, out_valid32, out_valid64, out_tag32);
      end
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_imm_type = 3'd4; in_inst = $urandom; in_tag = 32'h31;
    @(negedge clk);
    in_tag = 32'h32;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid32 !== 1'b0 || out_imm32 !== 32'h0 || out_imm64 !== 64'h0 || out_tag32 !== 32'h0 ||
        in_ready32 !== 1'b0 || in_ready64 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: v32=%b imm32=%h imm64=%h tag32=%h rdy32=%b rdy64=%b, expected all 0",
               out_valid32, out_imm32, out_imm64, out_tag32, in_ready32, in_ready64);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1 || out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_release: rdy32=%b rdy64=%b v32=%b v64=%b, expected rdy=1 v=0",
               in_ready32, in_ready64, out_valid32, out_valid64);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [64:0] r;
    exp_t e;
    logic push, pop;
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid32 !== (q.size() != 0) || in_ready32 !== (q.size() != 2) ||
          out_valid64 !== (q.size() != 0) || in_ready64 !== (q.size() != 2)) begin
        n_fail++;
        $display("FAIL rand_flow c%0d: v32=%b rdy32=%b v64=%b rdy64=%b, expected occupancy %0d",
                 cyc, out_valid32, in_ready32, out_valid64, in_ready64, q.size());
      end
      if (q.size() != 0) begin
        n_checks++;
        if (out_imm32 !== q[0].imm32 || out_illegal32 !== q[0].ill32 || out_tag32 !== q[0].tag ||
            out_imm64 !== q[0].imm64 || out_illegal64 !== q[0].ill64 || out_tag64 !== q[0].tag) begin
          n_fail++;
          $display("FAIL rand_data c%0d: imm32=%h ill32=%b imm64=%h ill64=%b tag=%h/%h, expected %h %b %h %b %h",
                   cyc, out_imm32, out_illegal32, out_imm64, out_illegal64, out_tag32, out_tag64,
                   q[0].imm32, q[0].ill32, q[0].imm64, q[0].ill64, q[0].tag);
        end
      end
      w = $urandom;
      in_inst = w[31:7];
      in_imm_type = 3'($urandom_range(0, 7));
      in_tag = $urandom;
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 24) == 0);
      r = ref_imm(w, in_imm_type, 32);
      e.imm32 = r[31:0]; e.ill32 = r[64];
      r = ref_imm(w, in_imm_type, 64);
      e.imm64 = r[63:0]; e.ill64 = r[64];
      e.tag = in_tag;
      push = in_valid && (q.size() < 2);
      pop = out_ready && (q.size() > 0);
      @(posedge clk);
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
